// File: rtl/result_signature_checker.sv
// -----------------------------------------------------------------------------
// result_signature_checker
//
// Compresses a fixed-length stream of 32-bit result beats into a MISR
// signature and compares the final value against a golden signature.
//
// A run starts when `start` is sampled high in IDLE or DONE. The MISR is
// loaded with SEED. Each accepted beat (in_valid & in_ready) shifts the MISR
// and XORs in the data. The beat that brings the beat count to WINDOW moves
// the checker to DONE on the next cycle, with `pass` showing whether the final
// signature matches EXP_SIG. While in DONE, the signature, count, pass and
// timeout values are held until the next start.
//
// Optional feature: define RESULT_CHK_TIMEOUT_EN to abort a run after TIMEOUT
// consecutive RUN cycles without an accepted beat (DONE with timeout=1,
// pass=0). Without the macro, timeout is tied to 0 and RUN waits forever.
//
// Parameters:
//   WINDOW   beats per run (1..65535)
//   SEED     MISR value loaded at run start and on reset
//   EXP_SIG  golden signature
//   TIMEOUT  idle RUN cycles before abort (RESULT_CHK_TIMEOUT_EN only, >= 1)
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset (priority over all inputs)
//   start      begin a run (ignored while busy)
//   in_valid   in_data carries a result beat
//   in_data    32-bit result word
//   in_ready   beat accepted this cycle when in_valid is also high (RUN only)
//   busy       run in progress
//   done       run finished; pass/timeout/signature/count are final
//   pass       final signature == EXP_SIG (meaningful only while done)
//   timeout    last run aborted on idle timeout
//   signature  current MISR value
//   count      beats accepted in the current or last run
// -----------------------------------------------------------------------------
module result_signature_checker #(
    parameter int unsigned WINDOW  = 16,
    parameter logic [31:0] SEED    = 32'h0000_0000,
    parameter logic [31:0] EXP_SIG = 32'h0000_0000,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic [31:0] signature,
    output logic [15:0] count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Elaboration-time parameter sanity checks.
    if (WINDOW < 1 || WINDOW > 65535) begin : g_bad_window
        $error("result_signature_checker: WINDOW out of range 1..65535");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("result_signature_checker: TIMEOUT must be at least 1");
    end

    // Count value held just before the final beat of a run.
    localparam logic [15:0] LAST_CNT = 16'(WINDOW - 1);

    // One MISR step: shift left, feedback taps 31/21/1/0 into bit 0, fold data.
    function automatic logic [31:0] misr_next(input logic [31:0] s,
                                              input logic [31:0] d);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]} ^ d;
    endfunction

    state_e      state_q, state_d;
    logic [31:0] sig_q, sig_d;
    logic [15:0] count_q, count_d;
    logic        pass_q, pass_d;
    logic        accept;
    logic [31:0] sig_upd;

    assign accept  = in_valid & in_ready;
    assign sig_upd = misr_next(sig_q, in_data);

`ifdef RESULT_CHK_TIMEOUT_EN
    localparam logic [31:0] IDLE_LAST = 32'(TIMEOUT - 1);

    logic [31:0] idle_q, idle_d;
    logic        timeout_q, timeout_d;

    // Consecutive RUN cycles without an accepted beat; cleared outside RUN.
    always_comb begin
        idle_d = 32'd0;
        if (state_q == S_RUN && !accept) begin
            idle_d = idle_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idle_q    <= 32'd0;
            timeout_q <= 1'b0;
        end else begin
            idle_q    <= idle_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        count_d = count_q;
        pass_d  = pass_q;
`ifdef RESULT_CHK_TIMEOUT_EN
        timeout_d = timeout_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    sig_d   = SEED;
                    count_d = 16'd0;
                    pass_d  = 1'b0;
`ifdef RESULT_CHK_TIMEOUT_EN
                    timeout_d = 1'b0;
`endif
                end
            end
            S_RUN: begin
                if (accept) begin
                    sig_d   = sig_upd;
                    count_d = count_q + 16'd1;
                    // Compare the freshly updated signature, not the old one.
                    if (count_q == LAST_CNT) begin
                        state_d = S_DONE;
                        pass_d  = (sig_upd == EXP_SIG);
                    end
                end
`ifdef RESULT_CHK_TIMEOUT_EN
                else if (idle_q == IDLE_LAST) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                    pass_d    = 1'b0;
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sig_q   <= SEED;
            count_q <= 16'd0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            count_q <= count_d;
            pass_q  <= pass_d;
        end
    end

    assign in_ready  = (state_q == S_RUN);
    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign pass      = pass_q;
    assign signature = sig_q;
    assign count     = count_q;

endmodule

// File: tb/tb_result_signature_checker.sv
// -----------------------------------------------------------------------------
// tb_result_signature_checker
//
// Four checker instances share one stimulus bus:
//   k=0 WINDOW=1, SEED=0,          EXP_SIG=1
//   k=1 WINDOW=2, SEED=0,          EXP_SIG=3
//   k=2 WINDOW=2, SEED=0,          EXP_SIG=0
//   k=3 WINDOW=4, SEED=A5A50F0F,   EXP_SIG=0
// A behavioural model keeps, per instance, the run phase and the list of
// beats accepted in the current run. The expected signature is the fold of
// the MISR rule over that list, and the expected count is the list length.
// Directed scenarios add literal checks on top.
// -----------------------------------------------------------------------------
module tb_result_signature_checker;

    localparam int NI      = 4;
    localparam int TMO     = 8;
    localparam int PH_IDLE = 0;
    localparam int PH_RUN  = 1;
    localparam int PH_DONE = 2;

    logic        clk;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [31:0] in_data;

    logic        rdy_v  [NI];
    logic        busy_v [NI];
    logic        done_v [NI];
    logic        pass_v [NI];
    logic        to_v   [NI];
    logic [31:0] sig_v  [NI];
    logic [15:0] cnt_v  [NI];

    int tests_run;
    int tests_failed;

    result_signature_checker #(.WINDOW(1), .SEED(32'h0), .EXP_SIG(32'h1), .TIMEOUT(TMO)) u_w1 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy_v[0]), .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
        .timeout(to_v[0]), .signature(sig_v[0]), .count(cnt_v[0]));

    result_signature_checker #(.WINDOW(2), .SEED(32'h0), .EXP_SIG(32'h3), .TIMEOUT(TMO)) u_w2p (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy_v[1]), .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
        .timeout(to_v[1]), .signature(sig_v[1]), .count(cnt_v[1]));

    result_signature_checker #(.WINDOW(2), .SEED(32'h0), .EXP_SIG(32'h0), .TIMEOUT(TMO)) u_w2f (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy_v[2]), .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]),
        .timeout(to_v[2]), .signature(sig_v[2]), .count(cnt_v[2]));

    result_signature_checker #(.WINDOW(4), .SEED(32'hA5A5_0F0F), .EXP_SIG(32'h0), .TIMEOUT(TMO)) u_w4 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy_v[3]), .busy(busy_v[3]), .done(done_v[3]), .pass(pass_v[3]),
        .timeout(to_v[3]), .signature(sig_v[3]), .count(cnt_v[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model ----------------
    function automatic int m_win(input int k);
        case (k)
            0:       return 1;
            1, 2:    return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [31:0] m_seed(input int k);
        return (k == 3) ? 32'hA5A5_0F0F : 32'h0;
    endfunction

    function automatic logic [31:0] m_exp(input int k);
        case (k)
            0:       return 32'h1;
            1:       return 32'h3;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] misr_step(input logic [31:0] s, input logic [31:0] d);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]} ^ d;
    endfunction

    int          m_ph   [NI];
    logic [31:0] m_q    [NI][$];
    logic        m_pass [NI];
    logic        m_to   [NI];
    int          m_idle [NI];

    function automatic logic [31:0] m_fold(input int k);
        logic [31:0] s;
        s = m_seed(k);
        for (int i = 0; i < m_q[k].size(); i++) s = misr_step(s, m_q[k][i]);
        return s;
    endfunction

    initial begin
        for (int k = 0; k < NI; k++) begin
            m_ph[k] = PH_IDLE; m_pass[k] = 1'b0; m_to[k] = 1'b0; m_idle[k] = 0;
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (rst) begin
                m_ph[k] = PH_IDLE; m_q[k].delete(); m_pass[k] = 1'b0; m_to[k] = 1'b0; m_idle[k] = 0;
            end else if (m_ph[k] != PH_RUN) begin
                if (start) begin
                    m_ph[k] = PH_RUN; m_q[k].delete(); m_pass[k] = 1'b0; m_to[k] = 1'b0; m_idle[k] = 0;
                end
            end else if (in_valid) begin
                m_q[k].push_back(in_data);
                m_idle[k] = 0;
                if (m_q[k].size() == m_win(k)) begin
                    m_ph[k] = PH_DONE;
                    m_pass[k] = (m_fold(k) == m_exp(k));
                end
            end else begin
                m_idle[k]++;
`ifdef RESULT_CHK_TIMEOUT_EN
                if (m_idle[k] == TMO) begin
                    m_ph[k] = PH_DONE; m_to[k] = 1'b1; m_pass[k] = 1'b0;
                end
`endif
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of all instances against the model.
    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("u%0d.in_ready", k), 32'(rdy_v[k]),  32'(m_ph[k] == PH_RUN));
            chk($sformatf("u%0d.busy", k),     32'(busy_v[k]), 32'(m_ph[k] == PH_RUN));
            chk($sformatf("u%0d.done", k),     32'(done_v[k]), 32'(m_ph[k] == PH_DONE));
            chk($sformatf("u%0d.timeout", k),  32'(to_v[k]),   32'(m_to[k]));
            chk($sformatf("u%0d.signature", k), sig_v[k],      m_fold(k));
            chk($sformatf("u%0d.count", k),    32'(cnt_v[k]),  32'(m_q[k].size()));
            if (m_ph[k] == PH_DONE)
                chk($sformatf("u%0d.pass", k), 32'(pass_v[k]), 32'(m_pass[k]));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    logic [31:0] dv [4];
    logic [31:0] gold;

    initial begin
        tests_run = 0; tests_failed = 0;
        dv[0] = 32'h0000_0001; dv[1] = 32'h0000_0000;
        dv[2] = 32'h1234_5678; dv[3] = 32'hDEAD_BEEF;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 32'h0;
        repeat (3) tick();

        // Reset state
        chk("rst.busy", 32'(busy_v[3]), 32'd0);
        chk("rst.done", 32'(done_v[3]), 32'd0);
        chk("rst.ready", 32'(rdy_v[3]), 32'd0);
        chk("rst.count", 32'(cnt_v[3]), 32'd0);
        chk("rst.sig", sig_v[3], 32'hA5A5_0F0F);
        chk("pin.misr", misr_step(misr_step(32'h0, 32'h1), 32'h0), 32'h3);
        rst = 1'b0;
        tick();

        // Window 1/2 basics, then full window-4 run
        start = 1'b1; tick(); start = 1'b0;
        beat(dv[0]);
        chk("w1.done", 32'(done_v[0]), 32'd1);
        chk("w1.sig", sig_v[0], 32'h1);
        chk("w1.count", 32'(cnt_v[0]), 32'd1);
        beat(dv[1]);
        chk("w2p.sig", sig_v[1], 32'h3);
        chk("w2p.pass", 32'(pass_v[1]), 32'd1);
        chk("w2f.done", 32'(done_v[2]), 32'd1);
        chk("w2f.pass", 32'(pass_v[2]), 32'd0);
        beat(dv[2]);
        beat(dv[3]);
        chk("w4.done", 32'(done_v[3]), 32'd1);
        chk("w1.count_hold", 32'(cnt_v[0]), 32'd1);
        gold = sig_v[3];
        tick();

        // Gapped input: same four beats, in_valid every other cycle
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            beat(dv[i]);
            in_data = 32'hFFFF_FFFF;
            tick();
        end
        chk("gap.sig", sig_v[3], gold);
        chk("gap.count", 32'(cnt_v[3]), 32'd4);

        // Reset mid-run, then a clean run
        start = 1'b1; tick(); start = 1'b0;
        beat(dv[0]); beat(dv[1]);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("mrst.busy", 32'(busy_v[3]), 32'd0);
        chk("mrst.count", 32'(cnt_v[3]), 32'd0);
        chk("mrst.sig", sig_v[3], 32'hA5A5_0F0F);
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 4; i++) beat(dv[i]);
        chk("mrst.rerun_sig", sig_v[3], gold);

        // Start held through DONE -> back-to-back run
        start = 1'b1; tick();
        for (int i = 0; i < 4; i++) beat(dv[i]);
        chk("b2b.done", 32'(done_v[3]), 32'd1);
        tick();
        chk("b2b.busy", 32'(busy_v[3]), 32'd1);
        chk("b2b.count", 32'(cnt_v[3]), 32'd0);
        start = 1'b0;
        beat(dv[0]);
        start = 1'b1; beat(dv[1]); start = 1'b0;
        beat(dv[2]); beat(dv[3]);
        chk("midstart.count", 32'(cnt_v[3]), 32'd4);
        chk("midstart.sig", sig_v[3], gold);

        // Idle run: timeout abort or indefinite wait
        start = 1'b1; tick(); start = 1'b0;
`ifdef RESULT_CHK_TIMEOUT_EN
        repeat (TMO - 1) tick();
        chk("tmo.early_done", 32'(done_v[3]), 32'd0);
        tick();
        chk("tmo.done", 32'(done_v[3]), 32'd1);
        chk("tmo.flag", 32'(to_v[3]), 32'd1);
        chk("tmo.pass", 32'(pass_v[3]), 32'd0);
`else
        repeat (20) tick();
        chk("wait.busy", 32'(busy_v[3]), 32'd1);
        chk("wait.timeout", 32'(to_v[3]), 32'd0);
        chk("wait.done", 32'(done_v[3]), 32'd0);
`endif
        tick();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/result_signature_checker.md
RESULT_SIGNATURE_CHECKER -- requirements
Module: result_signature_checker

Interface
REQ-001 SHALL have parameter WINDOW, default 16, meaning the number of result beats compressed per run (legal range 1..65535).
REQ-002 SHALL have parameter SEED, default 32'h00000000, meaning the initial MISR value loaded at run start.
REQ-003 SHALL have parameter EXP_SIG, default 32'h00000000, meaning the golden signature compared at run end.
REQ-004 SHALL have parameter TIMEOUT, default 1024, meaning idle cycles in RUN before abort (used only when RESULT_CHK_TIMEOUT_EN is defined).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port start, input, 1 bit: begins a run when sampled high in IDLE or DONE.
REQ-008 SHALL have port in_valid, input, 1 bit: in_data holds a result beat.
REQ-009 SHALL have port in_data, input, 32 bits: result word to compress.
REQ-010 SHALL have port in_ready, output, 1 bit: checker accepts a beat this cycle.
REQ-011 SHALL have port busy, output, 1 bit: high in RUN.
REQ-012 SHALL have port done, output, 1 bit: high in DONE.
REQ-013 SHALL have port pass, output, 1 bit: final signature equals EXP_SIG; valid only while done=1.
REQ-014 SHALL have port timeout, output, 1 bit: last run aborted on idle timeout.
REQ-015 SHALL have port signature, output, 32 bits: current MISR value.
REQ-016 SHALL have port count, output, 16 bits: beats accepted in the current or last run.

Function
REQ-017 SHALL implement three states, IDLE, RUN and DONE, with busy and done decoded from state.
REQ-018 SHALL drive in_ready=1 only in RUN; an accepted beat is defined as in_valid & in_ready.
REQ-019 SHALL, on start in IDLE or DONE, enter RUN next cycle and load signature=SEED, count=0, pass=0, timeout=0.
REQ-020 SHALL ignore start while in RUN.
REQ-021 SHALL update the MISR per accepted beat: sig <= {sig[30:0], sig[31]^sig[21]^sig[1]^sig[0]} ^ in_data.
REQ-022 SHALL leave sig and count unchanged on any cycle without an accepted beat.
REQ-023 SHALL increment count by 1 per accepted beat; count SHALL NOT wrap within a legal run.
REQ-024 SHALL, on the accepted beat that makes count equal WINDOW, enter DONE next cycle with pass=(updated sig==EXP_SIG).
REQ-025 SHALL hold signature, count, pass and timeout stable in DONE until the next start.
REQ-026 SHALL, for a start sampled in DONE, clear done on the following cycle and begin a fresh run (back-to-back runs, no IDLE visit).
REQ-027 SHALL have a one-cycle latency from the last accepted beat to done=1.

Reset
REQ-028 SHALL, while rst=1, force state=IDLE, signature=SEED, count=0, pass=0, timeout=0, in_ready=0, busy=0, done=0.
REQ-029 SHALL abort a RUN in progress on reset, discarding partial signature and count.
REQ-030 SHALL give rst priority over start and in_valid in the same cycle.

Configuration
REQ-031 SHALL, with macro RESULT_CHK_TIMEOUT_EN defined, count consecutive RUN cycles without an accepted beat, reset that counter on every accepted beat, and on reaching TIMEOUT enter DONE with timeout=1, pass=0.
REQ-032 SHALL, without RESULT_CHK_TIMEOUT_EN, omit the idle counter, tie timeout to 0, and wait in RUN indefinitely.

Verification
REQ-033 SHALL cover: WINDOW=1, SEED=0, one beat 0x00000001 -> DONE after 1 cycle, signature=0x00000001, count=1.
REQ-034 SHALL cover: WINDOW=2, SEED=0, EXP_SIG=0x00000003, beats 0x1 then 0x0 -> signature=0x00000003, pass=1; EXP_SIG=0 -> pass=0.
REQ-035 SHALL cover: WINDOW=4, in_valid toggled every other cycle -> only 4 accepted beats counted, signature identical to a gap-free run with the same data.
REQ-036 SHALL cover: rst asserted after 2 of 4 beats -> IDLE, count=0, signature=SEED; new start yields a correct full-run signature.
REQ-037 SHALL cover: start held high through DONE -> immediate back-to-back run; start pulsed mid-RUN -> no effect on count.
REQ-038 SHALL cover: with RESULT_CHK_TIMEOUT_EN, TIMEOUT=8, no in_valid after start -> done=1, timeout=1, pass=0 after 8 idle cycles.
